fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request feeding a DEPTH-entry FIFO.
// Redirects discard queued entries and any response that belongs to a pre-redirect request.
module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        flush_pc_i,
  input  logic                     hold_i,
  output logic                     req_valid_o,
  output logic [ADDR_W-1:0]        req_addr_o,
  input  logic                     req_ready_i,
  input  logic                     resp_valid_i,
  input  logic [INSTR_W-1:0]       resp_instr_i,
  input  logic                     resp_err_i,
  output logic                     instr_valid_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic [ADDR_W-1:0]        pc_o,
  output logic                     instr_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_W / 8);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   held_addr_q, held_addr_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic                drop_pending_q, drop_pending_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
  logic                err_mem_q   [DEPTH];

  logic handshake, push, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      fetch_pc_q     <= RESET_PC;
      held_addr_q    <= RESET_PC;
      issued_q       <= RESET_PC;
      drop_pending_q <= 1'b0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      held_addr_q    <= held_addr_d;
      issued_q       <= issued_d;
      drop_pending_q <= drop_pending_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= issued_q;
      instr_mem_q[tail_q] <= resp_instr_i;
      err_mem_q[tail_q]   <= resp_err_i;
    end
  end

  // A flush wins over both push and pop; pointers wrap because DEPTH is a power of two.
  always_comb begin
    handshake = req_valid_o && req_ready_i;
    push      = (state_q == WAIT) && resp_valid_i && !flush_i;
    pop       = (count_q != '0) && !hold_i && !flush_i;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    held_addr_d    = held_addr_q;
    issued_d       = issued_q;
    drop_pending_d = drop_pending_q;
    case (state_q)
      IDLE: if (flush_i || (count_q < CW'(DEPTH))) state_d = REQ;
      REQ: begin
        if (handshake) begin
          issued_d       = req_addr_o;
          drop_pending_d = 1'b0;
          if (flush_i || drop_pending_q) begin
            state_d = DROP;
          end else begin
            state_d    = WAIT;
            fetch_pc_d = fetch_pc_q + STEP;
          end
        end else if (flush_i && !drop_pending_q) begin
          // The offered address must stay stable, so it is parked while fetch_pc takes the target.
          drop_pending_d = 1'b1;
          held_addr_d    = fetch_pc_q;
        end
      end
      WAIT: begin
        if (resp_valid_i) begin
          if (flush_i || (count_d < CW'(DEPTH))) state_d = REQ;
          else                                   state_d = IDLE;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: if (resp_valid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (flush_i) fetch_pc_d = flush_pc_i;
  end

  always_comb begin
    req_valid_o   = (state_q == REQ);
    req_addr_o    = drop_pending_q ? held_addr_q : fetch_pc_q;
    instr_valid_o = (count_q != '0);
    instr_o       = '0;
    pc_o          = '0;
    instr_err_o   = 1'b0;
    if (instr_valid_o) begin
      instr_o     = instr_mem_q[head_q];
      pc_o        = pc_mem_q[head_q];
      instr_err_o = err_mem_q[head_q];
    end
    count_o = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_queue;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  localparam int W_RESP = 0, W_INSTR = 1, W_REQ = 2, W_HS = 3, W_FULL = 4;

  logic                clk, rst, flush_i, hold_i, req_ready_i;
  logic                resp_valid_i, resp_err_i;
  logic [ADDR_W-1:0]   flush_pc_i, req_addr_o, pc_o;
  logic [INSTR_W-1:0]  resp_instr_i, instr_o;
  logic                req_valid_o, instr_valid_o, instr_err_o;
  logic [2:0]          count_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i), .hold_i(hold_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_instr_i(resp_instr_i), .resp_err_i(resp_err_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_err_o(instr_err_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: an offered request, at most one in-flight request, and the queue.
  typedef struct { logic [63:0] pc; logic [31:0] instr; logic err; } entry_t;
  entry_t      mq[$];
  logic [63:0] m_pc, m_offer_addr, m_inflight_addr;
  bit          m_offer, m_offer_doomed, m_inflight, m_doomed;

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_offer_addr = RESET_PC;
    m_inflight_addr = RESET_PC;
    m_offer = 0; m_offer_doomed = 0; m_inflight = 0; m_doomed = 0;
  endtask

  task automatic model_step();
    int cnt0;
    bit was_idle, pop, hs, got, pushed, offer_next;
    cnt0 = mq.size();
    was_idle = !m_offer && !m_inflight;
    pop = (cnt0 != 0) && !hold_i && !flush_i;
    hs = m_offer && req_ready_i;
    got = m_inflight && resp_valid_i;
    pushed = 0;
    offer_next = 0;
    if (pop) void'(mq.pop_front());
    if (got) begin
      if (!m_doomed && !flush_i) begin
        mq.push_back('{m_inflight_addr, resp_instr_i, resp_err_i});
        pushed = 1;
      end
      m_inflight = 0;
      offer_next = pushed ? (mq.size() < DEPTH) : 1'b1;
    end
    if (hs) begin
      m_inflight = 1;
      m_inflight_addr = m_offer_doomed ? m_offer_addr : m_pc;
      m_doomed = m_offer_doomed || flush_i;
      if (!m_doomed) m_pc = m_pc + 64'd4;
      m_offer = 0;
      m_offer_doomed = 0;
    end else if (m_offer && flush_i && !m_offer_doomed) begin
      m_offer_doomed = 1;
      m_offer_addr = m_pc;
    end
    if (flush_i) begin
      mq.delete();
      m_pc = flush_pc_i;
      if (m_inflight) m_doomed = 1;
      if (was_idle) offer_next = 1;
    end else if (was_idle) begin
      offer_next = (cnt0 < DEPTH);
    end
    if (offer_next) m_offer = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check_output("rst_req_valid", req_valid_o, 0);
        check_output("rst_req_addr", req_addr_o, RESET_PC);
        check_output("rst_instr_valid", instr_valid_o, 0);
        check_output("rst_instr", instr_o, 0);
        check_output("rst_pc", pc_o, 0);
        check_output("rst_err", instr_err_o, 0);
        check_output("rst_count", count_o, 0);
      end else begin
        check_output("req_valid", req_valid_o, m_offer);
        if (m_offer) check_output("req_addr", req_addr_o, m_offer_doomed ? m_offer_addr : m_pc);
        check_output("count", count_o, mq.size());
        check_output("instr_valid", instr_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
          check_output("head_pc", pc_o, mq[0].pc);
          check_output("head_instr", instr_o, mq[0].instr);
          check_output("head_err", instr_err_o, mq[0].err);
        end
      end
    end
  end

  // Memory responder: answers each accepted request in order after a configurable delay.
  typedef struct { logic [63:0] addr; int due; } pend_t;
  pend_t       pend[$];
  pend_t       cur;
  int          cyc = 0;
  int          delay_min = 0, delay_max = 0;
  bit          directed = 1;
  logic [63:0] err_addr = '1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && req_valid_o && req_ready_i)
        pend.push_back('{req_addr_o, cyc + 1 + int'($urandom_range(delay_max, delay_min))});
    end
  end

  initial begin
    resp_valid_i = 0; resp_instr_i = 0; resp_err_i = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        cur = pend.pop_front();
        resp_valid_i = 1;
        resp_instr_i = directed ? 32'h13 + ((cur.addr[31:0] - 32'h8000_0000) << 5) : $urandom;
        resp_err_i   = directed ? (cur.addr == err_addr) : ($urandom_range(9, 0) == 0);
      end else if (!directed && $urandom_range(9, 0) == 0) begin
        resp_valid_i = 1;
        resp_instr_i = $urandom;
        resp_err_i   = $urandom_range(1, 0) == 1;
      end else begin
        resp_valid_i = 0;
      end
    end
  end

  task automatic apply_stimulus(input bit fl, input logic [63:0] fpc, input bit hd,
                                input bit rdy, input bit rs);
    @(posedge clk); #1;
    flush_i = fl; flush_pc_i = fpc; hold_i = hd; req_ready_i = rdy; rst = rs;
  endtask

  function automatic bit cond_met(input int sel);
    case (sel)
      W_RESP:  return resp_valid_i;
      W_INSTR: return instr_valid_o;
      W_REQ:   return req_valid_o;
      W_HS:    return req_valid_o && req_ready_i;
      W_FULL:  return count_o == 3'd4;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_neg(input int sel, input string name, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cond_met(sel) && t < budget);
    check_output(name, cond_met(sel), 1);
  endtask

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(3, 0) == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
    return {32'h0, $urandom} & ~64'h3;
  endfunction

  initial begin
    rst = 1; flush_i = 0; flush_pc_i = 0; hold_i = 0; req_ready_i = 0;
    repeat (3) @(posedge clk);
    apply_stimulus(0, 0, 0, 1, 0);

    // Streaming: each response shows at the head one cycle later, in order.
    for (int k = 0; k < 3; k++) begin
      wait_neg(W_RESP, "stream_resp_seen", 40);
      @(negedge clk);
      check_output("stream_valid", instr_valid_o, 1);
      check_output("stream_pc", pc_o, RESET_PC + 64'(4 * k));
      check_output("stream_instr", instr_o, 32'h13 + 32'(128 * k));
    end

    // Reset in the middle of a WAIT: outputs take reset values at once.
    wait_neg(W_HS, "pre_reset_hs", 20);
    apply_stimulus(0, 0, 1, 1, 1);
    #1;
    check_output("async_rst_req_valid", req_valid_o, 0);
    check_output("async_rst_req_addr", req_addr_o, RESET_PC);
    check_output("async_rst_instr_valid", instr_valid_o, 0);
    check_output("async_rst_count", count_o, 0);
    check_output("async_rst_pc", pc_o, 0);
    err_addr = 64'h8000_0004;
    apply_stimulus(0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 1, 1, 0);
    wait_neg(W_REQ, "post_reset_req", 10);
    check_output("post_reset_addr", req_addr_o, RESET_PC);

    // Fill with the IF stage held, then drain and observe the error flag and resume address.
    wait_neg(W_FULL, "fill_reached", 60);
    check_output("fill_count", count_o, 4);
    check_output("fill_head_pc", pc_o, RESET_PC);
    repeat (5) begin
      @(negedge clk);
      check_output("full_no_req", req_valid_o, 0);
      check_output("full_count", count_o, 4);
    end
    apply_stimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("drain_pc", pc_o, RESET_PC + 64'(4 * k));
      check_output("drain_err", instr_err_o, (k == 1) ? 1 : 0);
    end

    // Flush while waiting on a slow response: that response is dropped.
    delay_min = 3; delay_max = 3;
    wait_neg(W_HS, "wait_flush_hs", 20);
    apply_stimulus(1, 64'h8000_0100, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("wait_flush_count", count_o, 0);
    wait_neg(W_REQ, "wait_flush_req", 20);
    check_output("wait_flush_addr", req_addr_o, 64'h8000_0100);

    // Flush while a request is stalled: the offered address holds until accepted, then is dropped.
    apply_stimulus(1, 64'h8000_0200, 0, 0, 0);
    repeat (3) begin
      apply_stimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      check_output("req_flush_valid", req_valid_o, 1);
      check_output("req_flush_addr_held", req_addr_o, 64'h8000_0100);
    end
    delay_min = 0; delay_max = 0;
    apply_stimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    wait_neg(W_REQ, "req_flush_next_req", 20);
    check_output("req_flush_new_addr", req_addr_o, 64'h8000_0200);
    wait_neg(W_INSTR, "req_flush_instr", 20);
    check_output("req_flush_head_pc", pc_o, 64'h8000_0200);

    // Randomized traffic against the model.
    directed = 0;
    delay_min = 0; delay_max = 3;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(29, 0) == 0, rand_pc(), $urandom_range(2, 0) == 0,
                     $urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0);
    end
    apply_stimulus(0, 0, 0, 1, 0);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
